// File: rtl/ifu_fetch_unit_pkg.sv
// Shared constants, state encoding and helpers for the instruction fetch unit.
package ifu_fetch_unit_pkg;

  localparam logic [63:0] IFU_RESET_PC   = 64'h0000_0000_8000_0000;
  localparam logic [31:0] IFU_NOP_INST   = 32'h0000_0013;
  localparam logic [63:0] IFU_ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [63:0] IFU_INST_BYTES = 64'd4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_KILL = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [63:0] align_pc(input logic [63:0] pc);
    return pc & IFU_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/ifu_fetch_unit_if.sv
// Instruction memory port: valid/ready request channel plus a valid-only, in-order response channel.
interface ifu_fetch_unit_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );

endinterface

// File: rtl/ifu_skid_buffer.sv
// IF/ID output register backed by a single skid entry that absorbs one response
// arriving while decode is stalled on a valid instruction.
module ifu_skid_buffer
  import ifu_fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INST = IFU_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [63:0] in_pc,
  input  logic [31:0] in_inst,
  input  logic        stall,
  input  logic        flush,
  output logic        full,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_inst
);

  logic         out_valid_q;
  fetch_entry_t out_q;
  logic         skid_valid_q;
  fetch_entry_t skid_q;
  fetch_entry_t in_entry_s;

  assign in_entry_s = '{pc: in_pc, inst: in_inst};

  // Output/skid update; a bubble keeps the last pc so pc_out stays meaningful.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_q        <= '{pc: 64'd0, inst: NOP_INST};
      skid_valid_q <= 1'b0;
      skid_q       <= '{pc: 64'd0, inst: 32'd0};
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      out_q.inst   <= NOP_INST;
      skid_valid_q <= 1'b0;
    end else if (!stall) begin
      if (skid_valid_q) begin
        out_valid_q  <= 1'b1;
        out_q        <= skid_q;
        skid_valid_q <= in_valid;
        if (in_valid) begin
          skid_q <= in_entry_s;
        end
      end else if (in_valid) begin
        out_valid_q <= 1'b1;
        out_q       <= in_entry_s;
      end else begin
        out_valid_q <= 1'b0;
        out_q.inst  <= NOP_INST;
      end
    end else if (in_valid) begin
      if (out_valid_q) begin
        skid_valid_q <= 1'b1;
        skid_q       <= in_entry_s;
      end else begin
        out_valid_q <= 1'b1;
        out_q       <= in_entry_s;
      end
    end
  end

  assign full      = skid_valid_q;
  assign out_valid = out_valid_q;
  assign out_pc    = out_q.pc;
  assign out_inst  = out_q.inst;

endmodule

// File: rtl/ifu_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, keeps at most one imem request in flight,
// and feeds the IF/ID boundary while honouring decode stalls and pipeline redirects.
module ifu_fetch_unit
  import ifu_fetch_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC = IFU_RESET_PC,
  parameter logic [31:0] NOP_INST = IFU_NOP_INST
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [63:0]        redirect_pc,
  ifu_fetch_unit_if.master   imem,
  output logic               inst_valid,
  output logic [63:0]        pc_out,
  output logic [31:0]        inst_out
);

  fetch_state_e state_q, state_d;
  logic [63:0]  fetch_pc_q, fetch_pc_d;
  logic [63:0]  req_pc_q, req_pc_d;
  logic [1:0]   stale_cnt_q, stale_cnt_d, stale_rst_s;
  logic         handshake_s;
  logic         resp_ours_s;
  logic         deliver_s;
  logic         skid_full_s;

  // Masked during rst so nothing is accepted that the reset logic cannot account for.
  assign imem.imem_req_valid = (state_q == S_REQ) && !rst;
  assign imem.imem_req_addr  = fetch_pc_q;

  assign handshake_s = imem.imem_req_valid && imem.imem_req_ready;
  assign resp_ours_s = imem.imem_resp_valid && (stale_cnt_q == 2'd0);
  assign deliver_s   = resp_ours_s && (state_q == S_WAIT) && !redirect_valid;

  // Responses still owed from before a reset are counted and swallowed on arrival.
  always_comb begin
    stale_cnt_d = stale_cnt_q;
    stale_rst_s = stale_cnt_q;
    if (imem.imem_resp_valid && (stale_cnt_q != 2'd0)) begin
      stale_cnt_d = stale_cnt_q - 2'd1;
    end else begin
      stale_cnt_d = stale_cnt_q;
    end
    if (((state_q == S_WAIT) || (state_q == S_KILL)) && !resp_ours_s) begin
      stale_rst_s = stale_cnt_d + 2'd1;
    end else begin
      stale_rst_s = stale_cnt_d;
    end
  end

  // Next-state and fetch PC selection.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = align_pc(redirect_pc);
      // If our request completes this very cycle nothing is left to kill.
      case (state_q)
        S_REQ:   state_d = handshake_s ? S_KILL : S_REQ;
        S_WAIT:  state_d = resp_ours_s ? S_REQ : S_KILL;
        S_KILL:  state_d = resp_ours_s ? S_REQ : S_KILL;
        S_HOLD:  state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (handshake_s) begin
            fetch_pc_d = fetch_pc_q + IFU_INST_BYTES;
            req_pc_d   = fetch_pc_q;
            state_d    = S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end
        S_WAIT: begin
          if (resp_ours_s) begin
            state_d = (stall && inst_valid) ? S_HOLD : S_REQ;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_KILL: begin
          state_d = resp_ours_s ? S_REQ : S_KILL;
        end
        S_HOLD: begin
          state_d = (!stall || !skid_full_s) ? S_REQ : S_HOLD;
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  // Fetch FSM state; only the stale-response count carries across rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_REQ;
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= 64'd0;
      stale_cnt_q <= stale_rst_s;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      stale_cnt_q <= stale_cnt_d;
    end
  end

  ifu_skid_buffer #(
    .NOP_INST (NOP_INST)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (deliver_s),
    .in_pc     (req_pc_q),
    .in_inst   (imem.imem_resp_data),
    .stall     (stall),
    .flush     (redirect_valid),
    .full      (skid_full_s),
    .out_valid (inst_valid),
    .out_pc    (pc_out),
    .out_inst  (inst_out)
  );

endmodule

// File: tb/tb_ifu_fetch_unit.sv
// Directed bench for ifu_fetch_unit: the bench plays instruction memory by hand, cycle by cycle.
module tb_ifu_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] I0 = 32'h0010_0093;
  localparam logic [31:0] I1 = 32'h0020_0113;
  localparam logic [31:0] I2 = 32'h0030_0193;
  localparam logic [31:0] I3 = 32'h0040_0213;
  localparam logic [31:0] I4 = 32'h0050_0293;
  localparam logic [31:0] I5 = 32'h0060_0313;
  localparam logic [31:0] I6 = 32'h0070_0393;
  localparam logic [31:0] I7 = 32'h0080_0413;
  localparam logic [31:0] I8 = 32'h0090_0493;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic [63:0] pc_out;
  logic [31:0] inst_out;
  int          checks;
  int          errors;

  ifu_fetch_unit_if imem_bus ();

  ifu_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem_bus),
    .inst_valid     (inst_valid),
    .pc_out         (pc_out),
    .inst_out       (inst_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [63:0] pc, input logic [31:0] inst);
    chk({tag, "_valid"}, 64'(inst_valid), 64'(v));
    chk({tag, "_pc"}, pc_out, pc);
    chk({tag, "_inst"}, 64'(inst_out), 64'(inst));
  endtask

  task automatic chk_req(input string tag, input logic v, input logic [63:0] addr);
    chk({tag, "_req_valid"}, 64'(imem_bus.imem_req_valid), 64'(v));
    chk({tag, "_req_addr"}, imem_bus.imem_req_addr, addr);
  endtask

  task automatic mem(input logic ready, input logic rvalid, input logic [31:0] data);
    imem_bus.imem_req_ready  = ready;
    imem_bus.imem_resp_valid = rvalid;
    imem_bus.imem_resp_data  = data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 64'd0;
    mem(1'b0, 1'b0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Reset state and zero-wait streaming.
    chk_out("rst", 1'b0, 64'd0, NOP);
    chk_req("rst", 1'b1, RST_PC);
    mem(1'b1, 1'b0, 32'd0); step();
    chk_req("wait0", 1'b0, 64'h8000_0004);
    mem(1'b0, 1'b1, I0); step();
    chk_out("d0", 1'b1, 64'h8000_0000, I0);
    chk_req("d0", 1'b1, 64'h8000_0004);
    mem(1'b1, 1'b0, 32'd0); step();
    chk_out("bubble0", 1'b0, 64'h8000_0000, NOP);
    mem(1'b0, 1'b1, I1); step();
    chk_out("d1", 1'b1, 64'h8000_0004, I1);
    chk_req("d1", 1'b1, 64'h8000_0008);

    // Request held while memory is not ready.
    mem(1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_req("notready", 1'b1, 64'h8000_0008);
    end
    mem(1'b1, 1'b0, 32'd0); step();
    chk_req("accepted", 1'b0, 64'h8000_000C);
    mem(1'b0, 1'b1, I2); step();
    chk_out("d2", 1'b1, 64'h8000_0008, I2);

    // Stall for 4 cycles: next response goes to the skid, no further request.
    stall = 1'b1;
    mem(1'b1, 1'b0, 32'd0); step();
    chk_out("stall1", 1'b1, 64'h8000_0008, I2);
    mem(1'b0, 1'b1, I3); step();
    chk_out("stall2", 1'b1, 64'h8000_0008, I2);
    chk_req("stall2", 1'b0, 64'h8000_0010);
    mem(1'b0, 1'b0, 32'd0); step();
    chk_req("stall3", 1'b0, 64'h8000_0010);
    step();
    chk_out("stall4", 1'b1, 64'h8000_0008, I2);
    chk_req("stall4", 1'b0, 64'h8000_0010);
    stall = 1'b0; step();
    chk_out("skid", 1'b1, 64'h8000_000C, I3);
    chk_req("resume", 1'b1, 64'h8000_0010);

    // Redirect during WAIT drops the in-flight response.
    mem(1'b1, 1'b0, 32'd0); step();
    redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_8000_1002;
    mem(1'b0, 1'b0, 32'd0); step();
    redirect_valid = 1'b0;
    chk_req("kill", 1'b0, 64'h8000_1000);
    chk("kill_valid", 64'(inst_valid), 64'd0);
    mem(1'b0, 1'b1, 32'hDEAD_BEEF); step();
    chk("dropped_valid", 64'(inst_valid), 64'd0);
    chk("dropped_inst", 64'(inst_out), 64'(NOP));
    chk_req("retarget", 1'b1, 64'h8000_1000);
    mem(1'b1, 1'b0, 32'd0); step();
    mem(1'b0, 1'b1, I4); step();
    chk_out("d4", 1'b1, 64'h8000_1000, I4);

    // Redirect together with stall while the skid is full.
    stall = 1'b1;
    mem(1'b1, 1'b0, 32'd0); step();
    mem(1'b0, 1'b1, I5); step();
    chk_out("full", 1'b1, 64'h8000_1000, I4);
    chk_req("full", 1'b0, 64'h8000_1008);
    redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_8000_2000;
    mem(1'b0, 1'b0, 32'd0); step();
    redirect_valid = 1'b0;
    chk("flush_valid", 64'(inst_valid), 64'd0);
    chk("flush_inst", 64'(inst_out), 64'(NOP));
    chk_req("flush", 1'b1, 64'h8000_2000);
    stall = 1'b0; step();
    chk("skid_cleared", 64'(inst_valid), 64'd0);
    mem(1'b1, 1'b0, 32'd0); step();
    mem(1'b0, 1'b1, I6); step();
    chk_out("d6", 1'b1, 64'h8000_2000, I6);

    // Redirect with a same-cycle handshake, unaligned target, then PC wrap.
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    mem(1'b1, 1'b0, 32'd0); step();
    redirect_valid = 1'b0;
    chk_req("hs_kill", 1'b0, 64'hFFFF_FFFF_FFFF_FFFC);
    mem(1'b0, 1'b1, 32'h0BAD_0BAD); step();
    chk("hs_dropped", 64'(inst_valid), 64'd0);
    chk_req("wrap_req", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    mem(1'b1, 1'b0, 32'd0); step();
    chk_req("wrap", 1'b0, 64'd0);
    mem(1'b0, 1'b1, I7); step();
    chk_out("d7", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, I7);
    chk_req("d7", 1'b1, 64'd0);

    // Reset in WAIT; the old response arrives after reset and must be discarded.
    mem(1'b1, 1'b0, 32'd0); step();
    rst = 1'b1;
    mem(1'b0, 1'b0, 32'd0); step();
    chk_out("mid_rst", 1'b0, 64'd0, NOP);
    rst = 1'b0;
    mem(1'b1, 1'b0, 32'd0); #1;
    chk_req("post_rst", 1'b1, RST_PC);
    step();
    mem(1'b0, 1'b1, 32'hBADB_AD00); step();
    chk("stale_valid", 64'(inst_valid), 64'd0);
    chk("stale_req", 64'(imem_bus.imem_req_valid), 64'd0);
    mem(1'b0, 1'b1, I8); step();
    chk_out("d8", 1'b1, RST_PC, I8);
    mem(1'b0, 1'b0, 32'd0); step();
    chk_req("end", 1'b1, 64'h8000_0004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
